// File: rtl/board_gpio_ctrl_if.sv
// Board GPIO bundle: DIP switch inputs, debounced switch reports and LED controls.
interface board_gpio_ctrl_if #(
    parameter int unsigned NUM_SW  = 4,
    parameter int unsigned NUM_LED = 4
);
    logic [NUM_SW-1:0]    dip_switches_tri_i;
    logic [NUM_SW-1:0]    sw_o;
    logic                 sw_chg_o;
    logic [2*NUM_LED-1:0] led_mode_i;
    logic [NUM_LED-1:0]   led_val_i;
    logic [NUM_LED-1:0]   led_act_i;
    logic [NUM_LED-1:0]   led_4bits_tri_o;

    // Controller side
    modport slave (
        input  dip_switches_tri_i,
        input  led_mode_i,
        input  led_val_i,
        input  led_act_i,
        output sw_o,
        output sw_chg_o,
        output led_4bits_tri_o
    );

    // Subsystem / board side
    modport master (
        output dip_switches_tri_i,
        output led_mode_i,
        output led_val_i,
        output led_act_i,
        input  sw_o,
        input  sw_chg_o,
        input  led_4bits_tri_o
    );
endinterface

// File: rtl/board_gpio_ctrl.sv
// Board I/O controller: synchronised, debounced DIP switches with change strobe,
// and per-LED static / blink / activity-stretch / heartbeat drive.
module board_gpio_ctrl #(
    parameter int unsigned NUM_SW          = 4,
    parameter int unsigned NUM_LED         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned BLINK_DIV       = 12500000,
    parameter int unsigned STRETCH_TICKS   = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    board_gpio_ctrl_if.slave gpio
);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PRE_W = $clog2(BLINK_DIV);
    localparam int unsigned ST_W  = $clog2(STRETCH_TICKS + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);
    localparam logic [ST_W-1:0]  ST_LOAD  = ST_W'(STRETCH_TICKS);

    logic [NUM_SW-1:0]  sync1_q, sync1_d;
    logic [NUM_SW-1:0]  sync2_q, sync2_d;
    logic [DB_W-1:0]    db_cnt_q [NUM_SW];
    logic [DB_W-1:0]    db_cnt_d [NUM_SW];
    logic [NUM_SW-1:0]  sw_q, sw_d;
    logic               sw_chg_q, sw_chg_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [2:0]         tick_cnt_q, tick_cnt_d;
    logic [ST_W-1:0]    st_q [NUM_LED];
    logic [ST_W-1:0]    st_d [NUM_LED];
    logic [NUM_LED-1:0] led_q, led_d;
    logic               tick;
    logic               sw_upd;

    // Next-state logic for the switch path, prescaler, stretch counters and LEDs
    always_comb begin
        sync1_d    = gpio.dip_switches_tri_i;
        sync2_d    = sync1_q;
        sw_d       = sw_q;
        sw_upd     = 1'b0;
        tick       = (pre_q == PRE_LAST);
        pre_d      = tick ? '0 : pre_q + PRE_W'(1);
        tick_cnt_d = tick ? tick_cnt_q + 3'd1 : tick_cnt_q;
        led_d      = '0;

        // Counter runs only while the synchronised level disagrees with the accepted one
        for (int i = 0; i < NUM_SW; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != sw_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    sw_d[i] = sync2_q[i];
                    sw_upd  = 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        sw_chg_d = sw_upd;

        // A fresh activity pulse takes priority over a same-cycle tick decrement
        for (int i = 0; i < NUM_LED; i++) begin
            st_d[i] = st_q[i];
            if (gpio.led_act_i[i]) begin
                st_d[i] = ST_LOAD;
            end else if (tick && (st_q[i] != '0)) begin
                st_d[i] = st_q[i] - ST_W'(1);
            end

            case (gpio.led_mode_i[2*i +: 2])
                2'b00:   led_d[i] = gpio.led_val_i[i];
                2'b01:   led_d[i] = tick_cnt_q[0];
                2'b10:   led_d[i] = (st_q[i] != '0);
                default: led_d[i] = (tick_cnt_q == 3'd0) || (tick_cnt_q == 3'd2);
            endcase
        end
    end

    // State registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sw_q       <= '0;
            sw_chg_q   <= 1'b0;
            pre_q      <= '0;
            tick_cnt_q <= '0;
            led_q      <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < NUM_LED; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sw_q       <= sw_d;
            sw_chg_q   <= sw_chg_d;
            pre_q      <= pre_d;
            tick_cnt_q <= tick_cnt_d;
            led_q      <= led_d;
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < NUM_LED; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    assign gpio.sw_o            = sw_q;
    assign gpio.sw_chg_o        = sw_chg_q;
    assign gpio.led_4bits_tri_o = led_q;
endmodule

// File: tb/tb_board_gpio_ctrl.sv
// Directed bench for board_gpio_ctrl with a per-cycle expectation scoreboard.
module tb_board_gpio_ctrl;
    localparam int unsigned NSW  = 4;
    localparam int unsigned NLED = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    always #5 sys_clk = ~sys_clk;

    board_gpio_ctrl_if #(.NUM_SW(NSW), .NUM_LED(NLED)) gpio ();

    board_gpio_ctrl #(
        .NUM_SW         (NSW),
        .NUM_LED        (NLED),
        .DEBOUNCE_CYCLES(4),
        .BLINK_DIV      (5),
        .STRETCH_TICKS  (2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .gpio     (gpio)
    );

    typedef struct {
        int         at_k;
        int         sel;
        logic [3:0] exp;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   k      = 0;

    // One comparison
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Outputs after edge kk of a run started at reset release, for the phase-1 stimulus schedule
    function automatic logic blink(input int kk);
        return 1'(((kk - 1) / 5) % 2);
    endfunction

    function automatic logic hb(input int kk);
        int t;
        t = ((kk - 1) / 5) % 8;
        return (t == 0) || (t == 2);
    endfunction

    function automatic logic [3:0] exp_sw(input int kk);
        if (kk < 6)  return 4'b0000;
        if (kk < 26) return 4'b0100;
        return 4'b1110;
    endfunction

    function automatic logic exp_led2(input int kk);
        return ((kk >= 23) && (kk <= 30)) || ((kk >= 41) && (kk <= 50));
    endfunction

    function automatic logic exp_led3(input int kk);
        if (kk <= 30) return 1'b1;
        if (kk <= 35) return 1'b0;
        return blink(kk);
    endfunction

    task automatic push_expect(input int kk);
        exp_t e;
        e.at_k = kk;
        e.sel = 0; e.exp = exp_sw(kk);                  e.tag = $sformatf("sw_o@k%0d", kk);     sb_q.push_back(e);
        e.sel = 1; e.exp = {3'b000, (kk == 6) || (kk == 26)}; e.tag = $sformatf("sw_chg@k%0d", kk); sb_q.push_back(e);
        e.sel = 2; e.exp = {3'b000, blink(kk)};         e.tag = $sformatf("led0_blink@k%0d", kk); sb_q.push_back(e);
        e.sel = 3; e.exp = {3'b000, hb(kk)};            e.tag = $sformatf("led1_hb@k%0d", kk);    sb_q.push_back(e);
        e.sel = 4; e.exp = {3'b000, exp_led2(kk)};      e.tag = $sformatf("led2_act@k%0d", kk);   sb_q.push_back(e);
        e.sel = 5; e.exp = {3'b000, exp_led3(kk)};      e.tag = $sformatf("led3@k%0d", kk);       sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [3:0] obs;
        while ((sb_q.size() > 0) && (sb_q[0].at_k <= k)) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       obs = gpio.sw_o;
                1:       obs = {3'b000, gpio.sw_chg_o};
                2:       obs = {3'b000, gpio.led_4bits_tri_o[0]};
                3:       obs = {3'b000, gpio.led_4bits_tri_o[1]};
                4:       obs = {3'b000, gpio.led_4bits_tri_o[2]};
                default: obs = {3'b000, gpio.led_4bits_tri_o[3]};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        k++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sw_o"}, gpio.sw_o, 4'b0000);
        check({tag, "_sw_chg"}, {3'b000, gpio.sw_chg_o}, 4'b0000);
        check({tag, "_led"}, gpio.led_4bits_tri_o, 4'b0000);
    endtask

    initial begin
        sys_rst_n               = 1'b0;
        gpio.dip_switches_tri_i = '0;
        gpio.led_mode_i         = {2'b00, 2'b10, 2'b11, 2'b01};
        gpio.led_val_i          = 4'b1001;
        gpio.led_act_i          = '0;

        // Held in reset: everything stays clear even with timed modes selected
        repeat (3) step();
        check_all_zero("reset");

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        k = 0;

        // Phase 1: debounce, glitch rejection, blink, heartbeat, activity, static, mode change
        for (int kk = 0; kk < 52; kk++) begin
            case (kk)
                0:  gpio.dip_switches_tri_i[2] = 1'b1;
                10: gpio.dip_switches_tri_i[0] = 1'b1;
                13: gpio.dip_switches_tri_i[0] = 1'b0;
                20: begin
                    gpio.dip_switches_tri_i[1] = 1'b1;
                    gpio.dip_switches_tri_i[3] = 1'b1;
                end
                21: gpio.led_act_i[2] = 1'b1;
                22: gpio.led_act_i[2] = 1'b0;
                30: gpio.led_val_i = 4'b0000;
                35: gpio.led_mode_i[7:6] = 2'b01;
                39: gpio.led_act_i[2] = 1'b1;
                40: gpio.led_act_i[2] = 1'b0;
                default: ;
            endcase
            push_expect(kk + 1);
            step();
            drain();
        end

        // Mid-debounce and mid-stretch asynchronous reset
        gpio.dip_switches_tri_i = '0;
        step();
        gpio.led_act_i[2] = 1'b1;
        step();
        gpio.led_act_i[2] = 1'b0;
        step();
        step();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");

        gpio.dip_switches_tri_i = 4'b0100;
        gpio.led_mode_i         = {2'b00, 2'b10, 2'b11, 2'b01};
        gpio.led_val_i          = 4'b1001;
        repeat (3) begin
            step();
            check_all_zero("reset_hold");
        end

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        k = 0;

        // Phase 2: counters restart from zero, same switch latency as before
        for (int kk = 0; kk < 14; kk++) begin
            push_expect(kk + 1);
            step();
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
